// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Instruction fetch stage. Holds the PC and a direct-mapped,
//            one-word-per-line instruction cache. Misses are serviced through
//            the memory controller IF port. Hits are delivered to the
//            instruction queue at one per cycle. ROB redirects override
//            everything else.
//            Optional JAL prediction is built when IF_JAL_PREDICT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter int          ICACHE_IDX_BITS = 4,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic [31:0] if_to_mc_PC,
    output logic        if_to_mc_ready,
    input  logic [31:0] mc_to_if_inst,
    input  logic        mc_to_if_ready,

    input  logic        iq_full,
    output logic        if_to_iq_valid,
    output logic [31:0] if_to_iq_inst,
    output logic [31:0] if_to_iq_pc,
    output logic        if_to_iq_pred_taken,

    input  logic        rob_to_if_jump,
    input  logic [31:0] rob_to_if_target
);

    localparam int c_LINES = 1 << ICACHE_IDX_BITS;
    localparam int c_TAG_W = 32 - ICACHE_IDX_BITS - 2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [31:0]                r_pc;
    logic [31:0]                w_pc_nxt;
    logic                       r_mc_req;
    logic                       w_mc_req_nxt;
    logic [31:0]                r_mc_pc;
    logic [31:0]                w_mc_pc_nxt;
    logic                       r_iq_valid;
    logic                       w_iq_valid_nxt;
    logic [31:0]                r_iq_inst;
    logic [31:0]                w_iq_inst_nxt;
    logic [31:0]                r_iq_pc;
    logic [31:0]                w_iq_pc_nxt;
    logic                       r_iq_pred;
    logic                       w_iq_pred_nxt;

    logic [c_LINES-1:0]         r_valid;
    logic [c_TAG_W-1:0]         r_tag  [c_LINES];
    logic [31:0]                r_data [c_LINES];

    logic [ICACHE_IDX_BITS-1:0] w_idx;
    logic [c_TAG_W-1:0]         w_tag;
    logic                       w_hit;
    logic [31:0]                w_hit_data;
    logic                       w_fill;
    logic [ICACHE_IDX_BITS-1:0] w_fill_idx;
    logic [c_TAG_W-1:0]         w_fill_tag;
    logic                       w_is_jal;
    logic [31:0]                w_pc_adv;

    assign w_idx      = r_pc[ICACHE_IDX_BITS+1:2];
    assign w_tag      = r_pc[31:ICACHE_IDX_BITS+2];
    assign w_hit_data = r_data[w_idx];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Fills are addressed by the outstanding request, not the PC, because a
    // redirect may have moved the PC while the request was in flight.
    assign w_fill_idx = r_mc_pc[ICACHE_IDX_BITS+1:2];
    assign w_fill_tag = r_mc_pc[31:ICACHE_IDX_BITS+2];

`ifdef IF_JAL_PREDICT_EN
    logic [31:0] w_jal_imm;
    assign w_is_jal  = (w_hit_data[6:0] == 7'b1101111);
    assign w_jal_imm = {{11{w_hit_data[31]}}, w_hit_data[31], w_hit_data[19:12],
                        w_hit_data[20], w_hit_data[30:21], 1'b0};
    assign w_pc_adv  = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
`else
    assign w_is_jal  = 1'b0;
    assign w_pc_adv  = r_pc + 32'd4;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mc_req_nxt   = r_mc_req;
        w_mc_pc_nxt    = r_mc_pc;
        w_iq_valid_nxt = 1'b0;
        w_iq_inst_nxt  = r_iq_inst;
        w_iq_pc_nxt    = r_iq_pc;
        w_iq_pred_nxt  = r_iq_pred;
        w_fill         = 1'b0;

        case (r_state)
            ST_FETCH: begin
                if (rob_to_if_jump) begin
                    w_pc_nxt = rob_to_if_target;
                end else if (w_hit) begin
                    if (!iq_full) begin
                        w_iq_valid_nxt = 1'b1;
                        w_iq_inst_nxt  = w_hit_data;
                        w_iq_pc_nxt    = r_pc;
                        w_iq_pred_nxt  = w_is_jal;
                        w_pc_nxt       = w_pc_adv;
                    end
                end else begin
                    w_mc_req_nxt = 1'b1;
                    w_mc_pc_nxt  = r_pc;
                    w_state_nxt  = ST_WAIT;
                end
            end

            // The MC cannot abort, so a redirected request still completes
            // and its (address-correct) data is kept in the cache.
            ST_WAIT, ST_DROP: begin
                if (mc_to_if_ready) begin
                    w_fill       = 1'b1;
                    w_mc_req_nxt = 1'b0;
                    w_state_nxt  = ST_FETCH;
                end else if (rob_to_if_jump) begin
                    w_state_nxt  = ST_DROP;
                end
                if (rob_to_if_jump) begin
                    w_pc_nxt = rob_to_if_target;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_mc_req   <= 1'b0;
            r_mc_pc    <= 32'h0;
            r_iq_valid <= 1'b0;
            r_iq_inst  <= 32'h0;
            r_iq_pc    <= 32'h0;
            r_iq_pred  <= 1'b0;
            r_valid    <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mc_req   <= w_mc_req_nxt;
            r_mc_pc    <= w_mc_pc_nxt;
            r_iq_valid <= w_iq_valid_nxt;
            r_iq_inst  <= w_iq_inst_nxt;
            r_iq_pc    <= w_iq_pc_nxt;
            r_iq_pred  <= w_iq_pred_nxt;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mc_to_if_inst;
        end
    end

    assign if_to_mc_PC         = r_mc_pc;
    assign if_to_mc_ready      = r_mc_req;
    assign if_to_iq_valid      = r_iq_valid;
    assign if_to_iq_inst       = r_iq_inst;
    assign if_to_iq_pc         = r_iq_pc;
    assign if_to_iq_pred_taken = r_iq_pred;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Self-checking bench for ifetch_unit: directed scenarios plus
//            randomized traffic against a queue/array level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] if_to_mc_PC;
    logic        if_to_mc_ready;
    logic [31:0] mc_to_if_inst = 32'h0;
    logic        mc_to_if_ready = 1'b0;
    logic        iq_full = 1'b0;
    logic        if_to_iq_valid;
    logic [31:0] if_to_iq_inst;
    logic [31:0] if_to_iq_pc;
    logic        if_to_iq_pred_taken;
    logic        rob_to_if_jump = 1'b0;
    logic [31:0] rob_to_if_target = 32'h0;

    always #5 clk_in = ~clk_in;

    ifetch_unit #(
        .ICACHE_IDX_BITS (4),
        .RESET_PC        (32'h0)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .if_to_mc_PC         (if_to_mc_PC),
        .if_to_mc_ready      (if_to_mc_ready),
        .mc_to_if_inst       (mc_to_if_inst),
        .mc_to_if_ready      (mc_to_if_ready),
        .iq_full             (iq_full),
        .if_to_iq_valid      (if_to_iq_valid),
        .if_to_iq_inst       (if_to_iq_inst),
        .if_to_iq_pc         (if_to_iq_pc),
        .if_to_iq_pred_taken (if_to_iq_pred_taken),
        .rob_to_if_jump      (rob_to_if_jump),
        .rob_to_if_target    (rob_to_if_target)
    );

`ifdef IF_JAL_PREDICT_EN
    localparam logic [31:0] c_JAL_NEXT = 32'h10;
    localparam logic [31:0] c_JAL_PRED = 32'h1;
`else
    localparam logic [31:0] c_JAL_NEXT = 32'h4;
    localparam logic [31:0] c_JAL_PRED = 32'h0;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Memory image: explicit words override a hashed non-JAL filler.
    logic [31:0] mem_img [logic [31:0]];
    int          fixed_lat = 4;
    int          mc_lat    = 4;
    int          mc_wait   = 0;

    // Reference model: cache as arrays of (valid, word address, data).
    bit          m_cv [16];
    logic [31:0] m_ca [16];
    logic [31:0] m_cd [16];
    logic [31:0] m_pc       = 32'h0;
    bit          m_pend     = 1'b0;
    logic [31:0] m_req_pc   = 32'h0;
    bit          m_iq_valid = 1'b0;
    logic [31:0] m_iq_pc    = 32'h0;
    logic [31:0] m_iq_inst  = 32'h0;
    bit          m_pred     = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] h;
        if (mem_img.exists(a)) return mem_img[a];
        h = (a * 32'h9E3779B1) ^ 32'h3C5A7E11;
        return {h[31:7], 7'b0010011};
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd16);
    endfunction

    function automatic bit is_jal(input logic [31:0] inst);
`ifdef IF_JAL_PREDICT_EN
        return inst[6:0] == 7'b1101111;
`else
        return (inst == 32'h0) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] pc_after(input logic [31:0] pc, input logic [31:0] inst);
        logic [20:0] j;
        logic [31:0] ext;
        j   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        ext = {{11{j[20]}}, j};
        if (is_jal(inst)) return pc + ext;
        return pc + 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (!cmp_en) return;
        chk("iq_valid", {31'b0, if_to_iq_valid}, {31'b0, m_iq_valid});
        if (m_iq_valid) begin
            chk("iq_pc", if_to_iq_pc, m_iq_pc);
            chk("iq_inst", if_to_iq_inst, m_iq_inst);
            chk("iq_pred", {31'b0, if_to_iq_pred_taken}, {31'b0, m_pred});
        end
        chk("mc_ready", {31'b0, if_to_mc_ready}, {31'b0, m_pend});
        if (m_pend) chk("mc_pc", if_to_mc_PC, m_req_pc);
    endtask

    task automatic mc_respond();
        if (mc_to_if_ready) begin
            mc_to_if_ready = 1'b0;
        end else if (!rst_in && if_to_mc_ready === 1'b1) begin
            mc_wait++;
            if (mc_wait >= mc_lat && rdy_in) begin
                mc_to_if_ready = 1'b1;
                mc_to_if_inst  = mem_rd(if_to_mc_PC);
                mc_wait        = 0;
                mc_lat         = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            end
        end
        if (rst_in) mc_wait = 0;
    endtask

    task automatic model_step();
        int li;
        if (rst_in) begin
            m_pc = 32'h0; m_pend = 1'b0; m_req_pc = 32'h0;
            m_iq_valid = 1'b0; m_iq_pc = 32'h0; m_iq_inst = 32'h0; m_pred = 1'b0;
            for (int i = 0; i < 16; i++) m_cv[i] = 1'b0;
        end else if (rdy_in) begin
            m_iq_valid = 1'b0;
            if (m_pend) begin
                if (mc_to_if_ready) begin
                    li = line_of(m_req_pc);
                    m_cv[li] = 1'b1; m_ca[li] = m_req_pc; m_cd[li] = mc_to_if_inst;
                    m_pend = 1'b0;
                end
                if (rob_to_if_jump) m_pc = rob_to_if_target;
            end else if (rob_to_if_jump) begin
                m_pc = rob_to_if_target;
            end else begin
                li = line_of(m_pc);
                if (m_cv[li] && m_ca[li] == m_pc) begin
                    if (!iq_full) begin
                        m_iq_valid = 1'b1; m_iq_pc = m_pc; m_iq_inst = m_cd[li];
                        m_pred = is_jal(m_cd[li]);
                        m_pc = pc_after(m_pc, m_cd[li]);
                    end
                end else begin
                    m_pend = 1'b1; m_req_pc = m_pc;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic tick();
        compare();
        mc_respond();
        model_step();
        @(negedge clk_in);
    endtask

    function automatic bit cond(input int kind, input logic [31:0] val);
        case (kind)
            0:       return if_to_mc_ready === 1'b1;
            1:       return if_to_iq_valid === 1'b1;
            2:       return (if_to_iq_valid === 1'b1) && (if_to_iq_pc === val);
            default: return (if_to_mc_ready === 1'b1) && (if_to_mc_PC === val);
        endcase
    endfunction

    task automatic wait_for(input int kind, input logic [31:0] val, input int maxc, input string nm);
        int n = 0;
        while (!cond(kind, val) && n < maxc) begin
            tick();
            n++;
        end
        if (!cond(kind, val)) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: event absent after %0d cycles, required within %0d", nm, n, maxc);
        end
    endtask

    initial begin
        int i;
        // ---------------- reset values
        rst_in = 1'b1;
        model_step();
        @(negedge clk_in);
        cmp_en = 1'b1;
        tick();
        chk("rst_mc_ready", {31'b0, if_to_mc_ready}, 32'h0);
        chk("rst_mc_pc", if_to_mc_PC, 32'h0);
        chk("rst_iq_valid", {31'b0, if_to_iq_valid}, 32'h0);
        chk("rst_iq_inst", if_to_iq_inst, 32'h0);
        chk("rst_iq_pc", if_to_iq_pc, 32'h0);
        chk("rst_pred", {31'b0, if_to_iq_pred_taken}, 32'h0);

        // ---------------- first miss, MC latency 4
        mem_img[32'h0] = 32'h00000013;
        fixed_lat = 4; mc_lat = 4;
        rst_in = 1'b0;
        wait_for(0, 32'h0, 5, "t1_req");
        chk("t1_req_pc", if_to_mc_PC, 32'h0);
        for (i = 0; i < 4; i++) begin
            chk("t1_req_held", {31'b0, if_to_mc_ready}, 32'h1);
            chk("t1_req_pc_held", if_to_mc_PC, 32'h0);
            tick();
        end
        chk("t1_req_drop", {31'b0, if_to_mc_ready}, 32'h0);
        wait_for(1, 32'h0, 3, "t1_emit");
        chk("t1_emit_pc", if_to_iq_pc, 32'h0);
        chk("t1_emit_inst", if_to_iq_inst, 32'h00000013);
        wait_for(0, 32'h0, 5, "t1_next_req");
        chk("t1_next_req_pc", if_to_mc_PC, 32'h4);

        // ---------------- fill 0x0..0x3C, then replay from cache
        fixed_lat = 2;
        wait_for(2, 32'h3C, 400, "t2_fill");
        rob_to_if_jump = 1'b1; rob_to_if_target = 32'h0;
        tick();
        rob_to_if_jump = 1'b0;
        chk("t2_redir_quiet", {31'b0, if_to_iq_valid}, 32'h0);
        for (i = 0; i < 16; i++) begin
            tick();
            chk("t2_hit_valid", {31'b0, if_to_iq_valid}, 32'h1);
            chk("t2_hit_pc", if_to_iq_pc, 32'(i * 4));
            chk("t2_no_req", {31'b0, if_to_mc_ready}, 32'h0);
        end

        // ---------------- conflict miss: 0x40 evicts line 0
        wait_for(3, 32'h40, 5, "t3_req40");
        wait_for(2, 32'h40, 20, "t3_emit40");
        rob_to_if_jump = 1'b1; rob_to_if_target = 32'h0;
        tick();
        rob_to_if_jump = 1'b0;
        wait_for(0, 32'h0, 5, "t3_refetch");
        chk("t3_refetch_pc", if_to_mc_PC, 32'h0);

        // ---------------- redirect while waiting on 0x8
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        rob_to_if_jump = 1'b1; rob_to_if_target = 32'h8;
        fixed_lat = 8; mc_lat = 8;
        tick();
        rob_to_if_jump = 1'b0;
        wait_for(3, 32'h8, 5, "t4_req8");
        tick();
        tick();
        rob_to_if_jump = 1'b1; rob_to_if_target = 32'h100;
        tick();
        rob_to_if_jump = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (if_to_mc_ready !== 1'b1) break;
            chk("t4_held_pc", if_to_mc_PC, 32'h8);
            chk("t4_no_emit", {31'b0, if_to_iq_valid}, 32'h0);
            tick();
        end
        for (i = 0; i < 5; i++) begin
            if (if_to_mc_ready === 1'b1) break;
            chk("t4_drop_quiet", {31'b0, if_to_iq_valid}, 32'h0);
            tick();
        end
        chk("t4_next_req", {31'b0, if_to_mc_ready}, 32'h1);
        chk("t4_next_req_pc", if_to_mc_PC, 32'h100);

        // ---------------- iq_full stall during hits
        fixed_lat = 2; mc_lat = 2;
        wait_for(2, 32'h10C, 100, "t5_fill");
        rob_to_if_jump = 1'b1; rob_to_if_target = 32'h100;
        tick();
        rob_to_if_jump = 1'b0;
        tick();
        chk("t5_first_pc", if_to_iq_pc, 32'h100);
        chk("t5_first_valid", {31'b0, if_to_iq_valid}, 32'h1);
        iq_full = 1'b1;
        for (i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall_valid", {31'b0, if_to_iq_valid}, 32'h0);
            chk("t5_stall_req", {31'b0, if_to_mc_ready}, 32'h0);
        end
        iq_full = 1'b0;
        tick();
        chk("t5_resume_valid", {31'b0, if_to_iq_valid}, 32'h1);
        chk("t5_resume_pc", if_to_iq_pc, 32'h104);

        // ---------------- JAL at 0x0 (imm = +0x10)
        rst_in = 1'b1;
        mem_img[32'h0] = 32'h0100006F;
        tick();
        rst_in = 1'b0;
        wait_for(1, 32'h0, 20, "t6_emit");
        chk("t6_pc", if_to_iq_pc, 32'h0);
        chk("t6_inst", if_to_iq_inst, 32'h0100006F);
        chk("t6_pred", {31'b0, if_to_iq_pred_taken}, c_JAL_PRED);
        tick();
        wait_for(1, 32'h0, 20, "t6_next");
        chk("t6_next_pc", if_to_iq_pc, c_JAL_NEXT);

        // ---------------- randomized traffic (backward JAL at 0x20: imm -8)
        mem_img[32'h20] = 32'hFF9FF06F;
        fixed_lat = 0;
        rst_in = 1'b1;
        tick();
        for (i = 0; i < 4000; i++) begin
            rst_in         = ($urandom_range(0, 499) == 0);
            rdy_in         = ($urandom_range(0, 9) != 0);
            iq_full        = ($urandom_range(0, 3) == 0);
            rob_to_if_jump = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       rob_to_if_target = 32'($urandom_range(0, 31)) * 32'd4;
                1:       rob_to_if_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       rob_to_if_target = 32'h0000_0014;
                default: rob_to_if_target = $urandom() & 32'hFFFF_FFFC;
            endcase
            tick();
        end
        rst_in = 1'b0; rdy_in = 1'b1; rob_to_if_jump = 1'b0; iq_full = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
